// File: rtl/fp_pkg.sv
// fp_pkg: widths, state encoding and result record for the post-add normalizer
package fp_pkg;
    localparam int EXP_W = 4;
    localparam int FRAC_W = 6;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    typedef enum logic [1:0] {IDLE, NORM, DONE} norm_state_t;
    typedef struct packed {
        logic sign;
        logic [EXP_W-1:0] exp;
        logic [FRAC_W-1:0] frac;
        logic zero;
        logic ovf;
        logic unf;
    } fp_res_t;
endpackage

// File: rtl/fp_norm_step.sv
// fp_norm_step: one combinational normalization step (carry shift, zero, done, underflow, left shift); FP_NORM_ROUND_EN enables round-half-even on carry
module fp_norm_step import fp_pkg::*; (
    input  logic              sign,
    input  logic [EXP_W-1:0]  exp,
    input  logic [FRAC_W:0]   mag,
    output logic [EXP_W-1:0]  nxt_exp,
    output logic [FRAC_W:0]   nxt_mag,
    output logic              done,
    output fp_res_t           res
);
    logic [EXP_W-1:0] exp_inc;
    // priority-ordered step; an incomplete step only updates the working mag/exp
    always_comb begin
        exp_inc = exp + 1'b1;
        nxt_exp = exp;
        nxt_mag = mag;
        done = 1'b0;
        res = '0;
        res.sign = sign;
        if (mag[FRAC_W]) begin
            done = 1'b1;
            if (exp_inc == EXP_MAX || exp == EXP_MAX) begin
                res.ovf = 1'b1;
                res.exp = EXP_MAX;
                res.frac = '1;
            end else begin
                res.exp = exp_inc;
                res.frac = mag[FRAC_W:1];
`ifdef FP_NORM_ROUND_EN
                if (mag[1] & mag[0]) begin
                    if (&mag[FRAC_W:1]) begin
                        done = 1'b0;
                        nxt_mag = {1'b1, {FRAC_W{1'b0}}};
                        nxt_exp = exp_inc;
                    end else begin
                        res.frac = mag[FRAC_W:1] + 1'b1;
                    end
                end
`endif
            end
        end else if (mag == '0) begin
            done = 1'b1;
            res.zero = 1'b1;
        end else if (mag[FRAC_W-1]) begin
            done = 1'b1;
            res.exp = exp;
            res.frac = mag[FRAC_W-1:0];
        end else if (exp <= 1) begin
            done = 1'b1;
            res.unf = 1'b1;
            res.zero = 1'b1;
        end else begin
            nxt_mag = {mag[FRAC_W-1:0], 1'b0};
            nxt_exp = exp - 1'b1;
        end
    end
endmodule

// File: rtl/fp_norm_seq.sv
// fp_norm_seq: sequential one-bit-per-clock normalizer with valid/ready handshake; FP_NORM_ROUND_EN enables carry rounding
module fp_norm_seq import fp_pkg::*; (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [FRAC_W:0]   in_mag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [FRAC_W-1:0] out_frac,
    output logic              out_zero,
    output logic              out_ovf,
    output logic              out_unf
);
    norm_state_t state_q, state_d;
    logic sign_q;
    logic [EXP_W-1:0] exp_q, nxt_exp;
    logic [FRAC_W:0] mag_q, nxt_mag;
    logic done;
    fp_res_t step_res, res_q;

    fp_norm_step u_step (
        .sign(sign_q),
        .exp(exp_q),
        .mag(mag_q),
        .nxt_exp(nxt_exp),
        .nxt_mag(nxt_mag),
        .done(done),
        .res(step_res)
    );

    // state, working operand and held result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sign_q <= 1'b0;
            exp_q <= '0;
            mag_q <= '0;
            res_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && in_valid) begin
                sign_q <= in_sign;
                exp_q <= in_exp;
                mag_q <= in_mag;
            end
            if (state_q == NORM) begin
                exp_q <= nxt_exp;
                mag_q <= nxt_mag;
                if (done) res_q <= step_res;
            end
        end
    end

    // next state and handshake outputs
    always_comb begin
        state_d = state_q;
        in_ready = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = NORM;
            end
            NORM: if (done) state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_sign = res_q.sign;
    assign out_exp = res_q.exp;
    assign out_frac = res_q.frac;
    assign out_zero = res_q.zero;
    assign out_ovf = res_q.ovf;
    assign out_unf = res_q.unf;
endmodule

// File: doc/fp_norm_seq.md
Name: fp_norm_seq

Overview:
- Sequential post-add normalizer for the lab6 small floating-point adder/subtractor.
- Accepts the raw fraction magnitude produced by the add/sub stage, plus its carry-out, the provisional exponent and the result sign.
- Renormalizes one bit position per clock. Right shifts cover carry-out; left shifts cover leading zeros after subtraction.
- Emits a packed normalized result over a valid/ready handshake. Flags zero, overflow and underflow.

Parameters:
- EXP_W, 4, exponent width; all-ones exponent is reserved as overflow/saturation.
- FRAC_W, 6, fraction width including the explicit leading bit at position FRAC_W-1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- in_valid  input  1  operand presented
- in_ready  output  1  block can accept operand
- in_sign  input  1  result sign
- in_exp  input  EXP_W  provisional exponent (exponent of larger operand)
- in_mag  input  FRAC_W+1  magnitude; MSB is the add carry-out
- out_valid  output  1  result held valid
- out_ready  input  1  consumer accepts result
- out_sign  output  1  result sign
- out_exp  output  EXP_W  normalized exponent
- out_frac  output  FRAC_W  normalized fraction
- out_zero  output  1  result is exact zero
- out_ovf  output  1  exponent overflow, result saturated
- out_unf  output  1  underflow, result flushed to zero

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values:
  - state goes to IDLE, in_ready=1.
  - out_valid, out_sign, out_exp, out_frac, out_zero, out_ovf and out_unf are all 0.
  - Reset mid-operation discards the operand with no output.
- States:
  - IDLE: in_ready=1. When in_valid&in_ready, capture sign, exp and mag, go to NORM. in_ready=0 outside IDLE.
  - NORM: one step per edge, in priority order:
    1. Carry bit set: frac = mag[FRAC_W:1], exp+1, go to DONE. If exp+1 equals all-ones: out_ovf=1, exp=all-ones, frac=all-ones.
    2. mag==0: out_zero=1, exp=0, frac=0, go to DONE. Sign is kept.
    3. Bit FRAC_W-1 set: go to DONE unchanged.
    4. Otherwise, if exp==1 (i.e. exp<=1): out_unf=1, out_zero=1, exp=0, frac=0, go to DONE.
    5. Otherwise: shift left 1 with zero fill, exp-1, stay in NORM.
  - DONE: out_valid=1. Outputs are stable while out_valid&!out_ready. On out_ready, go to IDLE and clear out_valid. The next operand can be accepted on the following cycle; there is no pipelining.
- Latency, counted from the accepting edge: out_valid rises after 2+k edges, where k is the number of left shifts. Carry, zero and already-normalized inputs give k=0.
- Zero check compares the full FRAC_W+1 bits. Exponent arithmetic is unsigned EXP_W with no wrap, guaranteed by the overflow and underflow rules.
- in_valid while busy is ignored; the upstream stage must hold it.

Optional Feature:
- Macro: FP_NORM_ROUND_EN.
- Defined: on a carry right-shift, the dropped LSB is rounded half-to-even. Round up when the dropped bit is 1 and the new LSB is 1.
  - If rounding overflows the fraction, it takes one extra NORM cycle: frac = 1 followed by zeros, exp+1 again, with the same overflow rule.
- Undefined: the dropped bit is truncated and there is never an extra cycle.

Decomposition:
- Package fp_pkg:
  - EXP_W and FRAC_W defaults.
  - Derived EXP_MAX constant.
  - State enum norm_state_t {IDLE, NORM, DONE}.
  - Struct fp_res_t {sign, exp, frac, zero, ovf, unf}.
- One natural sub-module, fp_norm_step: the combinational single-step shifter/exponent updater with its priority logic. The top level holds the FSM, registers and handshake.

Test Plan (EXP_W=4, FRAC_W=6):
- Carry: in_mag=7'b1010110, in_exp=5 -> out_frac=6'b101011, out_exp=6, out_valid 2 edges after accept. With FP_NORM_ROUND_EN, in_mag=7'b1111111, in_exp=5 -> out_frac=6'b100000, out_exp=7, 3 edges.
- Leading zeros: in_mag=7'b0000101, in_exp=9 -> out_frac=6'b101000, out_exp=6, out_valid after 5 edges, flags 0.
- Zero: in_mag=0, in_exp=7, in_sign=1 -> out_zero=1, out_exp=0, out_frac=0, out_sign=1, 2 edges.
- Under/overflow:
  - in_mag=7'b0000001, in_exp=3 -> out_unf=1, out_zero=1, exp=0.
  - in_mag=7'b1000000, in_exp=14 -> out_ovf=1, out_exp=15, out_frac=6'b111111.
- Backpressure/reset:
  - Hold out_ready=0 for 4 cycles: outputs stable, in_ready=0, a second in_valid is ignored.
  - Assert reset during NORM: next cycle in_ready=1, out_valid=0, no result emitted.
